// File: rtl/jpeg_idct_transpose_ctrl.sv
// Transpose sequencer: fills the 64x16 RAM row-major, then drains it column-major into a 2-entry skid FIFO.
// Latency: the first output is valid 2 cycles after DRAIN is entered (1 issue cycle, 1 RAM read cycle); afterwards 1 sample/cycle.
// Backpressure: reads are issued only while FIFO + in-flight slots stay below 2, so a stalled consumer never loses data.
module jpeg_idct_transpose_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              inport_valid_i,
    input  logic [DATA_W-1:0] inport_data_i,
    output logic              inport_accept_o,
    output logic              outport_valid_o,
    output logic [DATA_W-1:0] outport_data_o,
    output logic [5:0]        outport_idx_o,
    output logic              outport_last_o,
    input  logic              outport_accept_i,
    output logic [5:0]        ram_addr0_o,
    output logic [DATA_W-1:0] ram_data0_o,
    output logic              ram_wr0_o,
    output logic [5:0]        ram_addr1_o,
    output logic [DATA_W-1:0] ram_data1_o,
    output logic              ram_wr1_o,
    input  logic [DATA_W-1:0] ram_data1_i,
    output logic              busy_o
);

    typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [5:0]        wr_cnt;
    logic [6:0]        rd_iss;
    logic              inflight;
    logic [5:0]        inflight_idx;
    logic [5:0]        addr1_hold;

    logic [DATA_W-1:0] fifo_data [2];
    logic [5:0]        fifo_idx  [2];
    logic              fifo_last [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              wr_fire;
    logic              pop;
    logic              push;
    logic              last_pop;
    logic              rd_issue;
    logic [2:0]        occ;
    logic [5:0]        rd_addr;

    // Datapath glue: write port, FIFO head presentation and read-issue decision.
    always_comb begin
        wr_fire         = inport_valid_i && inport_accept_o;
        ram_wr0_o       = wr_fire;
        ram_addr0_o     = wr_cnt;
        ram_data0_o     = inport_data_i;
        ram_data1_o     = '0;
        ram_wr1_o       = 1'b0;

        outport_valid_o = (fifo_cnt != 2'd0);
        outport_data_o  = outport_valid_o ? fifo_data[fifo_rd_ptr] : '0;
        outport_idx_o   = outport_valid_o ? fifo_idx[fifo_rd_ptr]  : 6'd0;
        outport_last_o  = outport_valid_o && fifo_last[fifo_rd_ptr];

        pop             = outport_valid_o && outport_accept_i;
        last_pop        = pop && outport_last_o;
        push            = inflight;

        // Slots committed after this edge: buffered + returning - leaving.
        occ             = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        rd_addr         = {rd_iss[2:0], rd_iss[5:3]};
        rd_issue        = (state == ST_DRAIN) && !flush_i && !rd_iss[6] && (occ < 3'd2);
        ram_addr1_o     = rd_issue ? rd_addr : addr1_hold;

        busy_o          = (state == ST_DRAIN) || (wr_cnt != 6'd0);
    end

    // Phase state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_FILL;
        else        state <= state_nxt;
    end

    // Phase transitions and input handshake; flush overrides everything.
    always_comb begin
        state_nxt       = state;
        inport_accept_o = 1'b0;
        if (flush_i) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    inport_accept_o = 1'b1;
                    if (inport_valid_i && (wr_cnt == 6'd63)) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_pop) state_nxt = ST_FILL;
                end
            endcase
        end
    end

    // Row-major write counter; wraps to 0 on the 64th write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       wr_cnt <= 6'd0;
        else if (flush_i) wr_cnt <= 6'd0;
        else if (wr_fire) wr_cnt <= wr_cnt + 6'd1;
    end

    // Read issue tracking; the address is held between issues.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_iss       <= 7'd0;
            inflight     <= 1'b0;
            inflight_idx <= 6'd0;
            addr1_hold   <= 6'd0;
        end else if (flush_i) begin
            rd_iss       <= 7'd0;
            inflight     <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                rd_iss       <= rd_iss + 7'd1;
                inflight_idx <= rd_addr;
                addr1_hold   <= rd_addr;
            end
            if (last_pop) rd_iss <= 7'd0;
        end
    end

    // Skid FIFO pointers and occupancy; RAM data in flight at flush is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (flush_i) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Skid FIFO storage; contents are only visible while the entry is valid.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            fifo_data[fifo_wr_ptr] <= ram_data1_i;
            fifo_idx[fifo_wr_ptr]  <= inflight_idx;
            fifo_last[fifo_wr_ptr] <= (inflight_idx == 6'd63);
        end
    end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Bench for the IDCT transpose sequencer: behavioural RAM, scoreboard of column-order samples.
// Directed steps: nominal timing, random stall, long stall, flush, async reset mid-drain, back-to-back blocks.
// A negedge monitor pops the scoreboard on every output handshake and checks hold-while-stalled.
module tb_jpeg_idct_transpose_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_accept;
    logic        out_valid;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        out_accept;
    logic [5:0]  ram_addr0;
    logic [15:0] ram_data0;
    logic        ram_wr0;
    logic [5:0]  ram_addr1;
    logic [15:0] ram_data1_o;
    logic        ram_wr1;
    logic [15:0] ram_rdata;
    logic        busy;

    logic [15:0] ram [64];
    exp_t        sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_vld_cyc = -1;
    int last_pop_cyc = -1;
    int fill_done_cyc = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [5:0]  prev_idx;
    logic        prev_last;

    jpeg_idct_transpose_ctrl #(.DATA_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .flush_i          (flush),
        .inport_valid_i   (in_valid),
        .inport_data_i    (in_data),
        .inport_accept_o  (in_accept),
        .outport_valid_o  (out_valid),
        .outport_data_o   (out_data),
        .outport_idx_o    (out_idx),
        .outport_last_o   (out_last),
        .outport_accept_i (out_accept),
        .ram_addr0_o      (ram_addr0),
        .ram_data0_o      (ram_data0),
        .ram_wr0_o        (ram_wr0),
        .ram_addr1_o      (ram_addr1),
        .ram_data1_o      (ram_data1_o),
        .ram_wr1_o        (ram_wr1),
        .ram_data1_i      (ram_rdata),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 64x16 dual-port RAM with 1-cycle synchronous read on port 1.
    always @(posedge clk) begin
        if (ram_wr0) ram[ram_addr0] <= ram_data0;
        ram_rdata <= ram[ram_addr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare on every pop, stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld",  32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data),  32'(prev_data));
                check("hold_idx",  32'(out_idx),   32'(prev_idx));
                check("hold_last", 32'(out_last),  32'(prev_last));
            end
            if (out_valid) begin
                check("no_accept_in_drain", 32'(in_accept), 32'd0);
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (out_valid && out_accept) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL extra_output: observed idx %0d data %0d expected no output", out_idx, out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_idx",  32'(out_idx),  32'(e.idx));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
                if (out_last) last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_accept;
            prev_data  = out_data;
            prev_idx   = out_idx;
            prev_last  = out_last;
        end
    end

    // Writes n samples base+i row-major; optionally queues the 64 column-order results.
    task automatic write_block(input int base, input int n, input bit push_exp);
        int   cnt;
        int   guard;
        bit   acc;
        exp_t e;
        cnt   = 0;
        guard = 0;
        in_valid = 1'b1;
        while (cnt < n && guard < 1000) begin
            in_data = 16'(base + cnt);
            @(negedge clk);
            acc = in_accept;
            @(posedge clk);
            #1;
            if (acc) cnt++;
            guard++;
        end
        in_valid = 1'b0;
        fill_done_cyc = cyc;
        check("fill_count", 32'(cnt), 32'(n));
        if (push_exp) begin
            for (int k = 0; k < 64; k++) begin
                e.idx  = 6'((k % 8) * 8 + k / 8);
                e.data = 16'(base + (k % 8) * 8 + k / 8);
                e.last = (k == 63);
                sb.push_back(e);
            end
        end
    endtask

    // Runs the consumer until the scoreboard is empty and the block is idle.
    task automatic drain_wait(input bit rnd);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 2000) begin
            out_accept = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            guard++;
        end
        out_accept = 1'b1;
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_idle",     32'(busy),      32'd0);
    endtask

    initial begin
        int c0;
        int p0;
        int guard;
        rst_n      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'd0;
        out_accept = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wr0",       32'(ram_wr0),   32'd0);
        check("rst_addr1",     32'(ram_addr1), 32'd0);
        check("rst_accept",    32'(in_accept), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal block, accept held high: check D2 first valid, D65 last pop, D66 refill.
        out_accept    = 1'b1;
        first_vld_cyc = -1;
        last_pop_cyc  = -1;
        write_block(0, 64, 1'b1);
        c0 = fill_done_cyc;
        repeat (66) @(negedge clk);
        check("accept_d65", 32'(in_accept), 32'd0);
        @(negedge clk);
        check("accept_d66", 32'(in_accept), 32'd1);
        check("first_valid_cycle", 32'(first_vld_cyc), 32'(c0 + 2));
        check("last_pop_cycle",    32'(last_pop_cyc),  32'(c0 + 65));
        check("sb_empty_nominal",  32'(sb.size()),     32'd0);
        @(posedge clk);
        #1;

        // Random consumer stalls.
        write_block(50, 64, 1'b1);
        drain_wait(1'b1);

        // Consumer stalled for 20 cycles from D0: only two reads may be issued.
        out_accept = 1'b0;
        write_block(600, 64, 1'b1);
        @(negedge clk);
        check("stall_addr_d0", 32'(ram_addr1), 32'd0);
        @(negedge clk);
        check("stall_addr_d1", 32'(ram_addr1), 32'd8);
        repeat (18) @(negedge clk);
        check("stall_addr_d19", 32'(ram_addr1), 32'd8);
        check("stall_valid",    32'(out_valid), 32'd1);
        check("stall_data",     32'(out_data),  32'd600);
        check("stall_idx",      32'(out_idx),   32'd0);
        @(posedge clk);
        #1;
        drain_wait(1'b0);

        // Flush after 30 writes; the following block must be unaffected.
        write_block(500, 30, 1'b0);
        check("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_accept", 32'(in_accept), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy",   32'(busy),      32'd0);
        check("flush_wr_cnt", 32'(ram_addr0), 32'd0);
        write_block(200, 64, 1'b1);
        drain_wait(1'b0);

        // Asynchronous reset after 10 outputs while reads are in flight.
        out_accept = 1'b1;
        p0 = pop_cnt;
        write_block(300, 64, 1'b1);
        guard = 0;
        while (pop_cnt < p0 + 10 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_mid_pops", 32'(pop_cnt), 32'(p0 + 10));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid",  32'(out_valid), 32'd0);
        check("rst_mid_accept", 32'(in_accept), 32'd1);
        check("rst_mid_busy",   32'(busy),      32'd0);
        check("rst_mid_last",   32'(out_last),  32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        write_block(400, 64, 1'b1);
        drain_wait(1'b0);

        // Back-to-back blocks with valid held high across the drain.
        write_block(0, 64, 1'b1);
        write_block(100, 64, 1'b1);
        drain_wait(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
